// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Channel count, debounce state encoding and the selector helper.
package btn_pkg;

    localparam int N_BTN = 3;

    // Bit 1 of the encoding is the debounced level.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMING    = 2'b01,
        HELD      = 2'b11,
        RELEASING = 2'b10
    } btn_state_t;

    function automatic logic [N_BTN-1:0] lowest_onehot(
        input logic [N_BTN-1:0] v
    );
        return v & (~v + 1'b1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, debounce FSM with
// counter, and registered press/release pulses.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic drop
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The entry edge already counts as the first stable sample.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

    logic [1:0]    sync;
    logic          s;
    btn_state_t    state;
    logic [CW-1:0] cnt;

    assign s     = sync[1];
    assign level = state[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
            drop  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            drop  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s) begin
                        state <= ARMING;
                        cnt   <= '0;
                    end
                end
                ARMING: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= RELEASING;
                        cnt   <= '0;
                    end
                end
                RELEASING: begin
                    if (s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        drop  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the raw buttons and grants at most one channel to the
// PWM stage through a latched, non-pre-emptive one-hot selector.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_sel
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .drop (btn_release[i])
        );
    end

    // A grant whose channel is still active is never pre-empted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_sel <= '0;
        end else if ((btn_sel & btn_level) == '0) begin
            btn_sel <= lowest_onehot(btn_level);
        end
    end

endmodule
